jt6295_cmd_seq: RTL and testbench



---
 rtl/jt6295_cmd_seq.sv | 197 +++++++++++++++++++
 tb/tb_jt6295_cmd_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt6295_cmd_seq.sv
// Script-driven command sequencer for the jt6295 CPU write bus (WR/WAIT/POLL/JUMP/END).
// Optional abort input enabled by defining JT6295_SEQ_ABORT_EN.
module jt6295_cmd_seq #(
  parameter int AW        = 5,
  parameter int NCHIP     = 2,
  parameter int WAIT_UNIT = 1024,
  parameter int WR_LEN    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 prog_we,
  input  logic [AW-1:0]        prog_addr,
  input  logic [12:0]          prog_data,
  input  logic                 start,
  input  logic [NCHIP*4-1:0]   ch_busy,
`ifdef JT6295_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  output logic [NCHIP-1:0]     wrn,
  output logic [7:0]           din,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        pc
);

  localparam int UW = $clog2(WAIT_UNIT);
  localparam int CW = 8 + UW;
  localparam logic [2:0] NCHIP_L = 3'(NCHIP);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WRLO, S_WRHI, S_WAIT, S_POLL
  } state_t;

  state_t            state_q, state_d;
  logic [NCHIP-1:0]  wrn_q, wrn_d;
  logic [7:0]        din_q, din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pend_q, pend_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [12:0]       mem [2**AW];
  logic [12:0]       rd_q;
  logic [2:0]        op;
  logic [1:0]        sel;
  logic [7:0]        data;
  logic [3:0]        nib [4];

  // Script RAM: loader writes only while idle; read port follows pc every clock.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_q)
      mem[prog_addr] <= prog_data;
    rd_q <= mem[pc_q];
  end

  assign op   = rd_q[12:10];
  assign sel  = rd_q[9:8];
  assign data = rd_q[7:0];

  // Chips that are not fitted read as permanently idle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    if (gi < NCHIP) begin : g_on
      assign nib[gi] = ch_busy[4*gi +: 4];
    end else begin : g_off
      assign nib[gi] = 4'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    wrn_d   = wrn_q;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pend_d  = pend_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    if (start && state_q == S_IDLE && !busy_q) begin
      pend_d = 1'b1;
      busy_d = 1'b1;
    end

    if (cen) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            pend_d  = 1'b0;
            pc_d    = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          state_d = S_FETCH;
          case (op)
            3'b000: begin
              if ({1'b0, sel} < NCHIP_L) begin
                din_d = data;
                for (int k = 0; k < NCHIP; k++)
                  if (sel == 2'(k)) wrn_d[k] = 1'b0;
                cnt_d   = CW'(WR_LEN - 1);
                state_d = S_WRLO;
              end else begin
                pc_d = pc_q + AW'(1);
              end
            end
            3'b001: begin
              if (data == 8'd0) begin
                pc_d = pc_q + AW'(1);
              end else begin
                cnt_d   = (CW'(data) << UW) - CW'(1);
                state_d = S_WAIT;
              end
            end
            3'b010: state_d = S_POLL;
            3'b011: pc_d = AW'(data);
            default: begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_WRLO: begin
          if (cnt_q == '0) begin
            wrn_d   = '1;
            state_d = S_WRHI;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_WRHI: begin
          pc_d    = pc_q + AW'(1);
          state_d = S_FETCH;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            pc_d    = pc_q + AW'(1);
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_POLL: begin
          if ((nib[sel] & data[3:0]) == 4'd0) begin
            pc_d    = pc_q + AW'(1);
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef JT6295_SEQ_ABORT_EN
    if (abort) begin
      wrn_d   = '1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pend_d  = 1'b0;
      state_d = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wrn_q   <= '1;
      din_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wrn_q   <= wrn_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wrn  = wrn_q;
  assign din  = din_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pc   = pc_q;

endmodule

// File: tb/tb_jt6295_cmd_seq.sv
// Directed scoreboard bench for jt6295_cmd_seq (AW=5, NCHIP=2, WAIT_UNIT=4, WR_LEN=2, cen=clk/4).
module tb_jt6295_cmd_seq;
  localparam int AW = 5;
  localparam int NCHIP = 2;

  logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0, prog_we = 1'b0, start = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [12:0] prog_data = '0;
  logic [NCHIP*4-1:0] ch_busy = '0;
  logic [NCHIP-1:0] wrn;
  logic [7:0] din;
  logic busy, done;
  logic [AW-1:0] pc;
`ifdef JT6295_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  jt6295_cmd_seq #(.AW(AW), .NCHIP(NCHIP), .WAIT_UNIT(4), .WR_LEN(2)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .ch_busy(ch_busy),
`ifdef JT6295_SEQ_ABORT_EN
    .abort(abort),
`endif
    .wrn(wrn), .din(din), .busy(busy), .done(done), .pc(pc)
  );

  typedef struct { int chip; int data; } exp_t;
  typedef struct { int chip; int data; int len; int fall; int din_ok; } obs_t;
  exp_t exp_q[$];
  obs_t obs_q[$];
  int falls[$];
  int total = 0, bad = 0, cyc = 0, cdiv = 0;
  int done_cnt = 0, overlap_cnt = 0;
  int d0, rel;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(negedge clk);
    cen = (cdiv == 0);
    cdiv = (cdiv + 1) % 4;
  end

  // Monitor: turns each wrn low pulse into an observed write (chip, byte, length in clk).
  logic [NCHIP-1:0] low, prev_low = '0;
  logic prev_done = 1'b0;
  obs_t cur;
  always @(negedge clk) begin
    low = ~wrn;
    if (low != '0 && (low & (low - 1'b1)) != '0) overlap_cnt++;
    if (prev_low == '0 && low != '0) begin
      for (int k = 0; k < NCHIP; k++) if (low[k]) cur.chip = k;
      cur.data = din; cur.len = 1; cur.fall = cyc; cur.din_ok = 1;
    end else if (prev_low != '0 && low != '0) begin
      cur.len++;
      if (din !== cur.data[7:0]) cur.din_ok = 0;
    end else if (prev_low != '0 && low == '0) begin
      obs_q.push_back(cur);
    end
    prev_low = low;
    if (done === 1'b1 && !prev_done) done_cnt++;
    prev_done = (done === 1'b1);
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [2:0] op, input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = {op, sel, d};
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    check(tag, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pc(input int v, input int budget, input string tag);
    int n = 0;
    while (pc !== AW'(v) && n < budget) begin @(negedge clk); n++; end
    check(tag, pc, v);
  endtask

  task automatic compare_writes(input string tag);
    exp_t e; obs_t o;
    falls.delete();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check({tag, "_count"}, obs_q.size(), 1);
      end else begin
        o = obs_q.pop_front();
        check({tag, "_chip"}, o.chip, e.chip);
        check({tag, "_din"}, o.data, e.data);
        check({tag, "_len"}, o.len, 8);
        check({tag, "_hold"}, o.din_ok, 1);
        falls.push_back(o.fall);
        $display("write chip=%0d din=%02h len=%0d t=%0d", o.chip, o.data, o.len, o.fall);
      end
    end
    check({tag, "_extra"}, obs_q.size(), 0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_wrn", wrn, 3); check("rst_din", din, 0); check("rst_busy", busy, 0);
    check("rst_done", done, 0); check("rst_pc", pc, 0);
    rst_n = 1'b1;

    // Three back-to-back writes to chip 0, then END.
    load(0, 3'b000, 2'd0, 8'h78); load(1, 3'b000, 2'd0, 8'h82);
    load(2, 3'b000, 2'd0, 8'h20); load(3, 3'b100, 2'd0, 8'h00);
    exp_q.push_back('{0, 8'h78}); exp_q.push_back('{0, 8'h82}); exp_q.push_back('{0, 8'h20});
    d0 = done_cnt;
    pulse_start();
    wait_idle(2000, "A_idle");
    compare_writes("A");
    check("A_gap1", falls[1] - falls[0], 20);  // WRLO,WRLO,WRHI,FETCH,DECODE = 5 cen
    check("A_gap2", falls[2] - falls[1], 20);
    check("A_done", done_cnt - d0, 1);
    check("A_pc", pc, 3);

    // WAIT 3 (12 cen) and WAIT 0 (no delay beyond its own FETCH/DECODE).
    load(0, 3'b000, 2'd0, 8'h11); load(1, 3'b001, 2'd0, 8'd3);
    load(2, 3'b000, 2'd0, 8'h22); load(3, 3'b001, 2'd0, 8'd0);
    load(4, 3'b000, 2'd0, 8'h33); load(5, 3'b100, 2'd0, 8'h00);
    exp_q.push_back('{0, 8'h11}); exp_q.push_back('{0, 8'h22}); exp_q.push_back('{0, 8'h33});
    pulse_start();
    wait_idle(2000, "B_idle");
    compare_writes("B");
    check("B_gap_wait3", falls[1] - falls[0], 76);  // 5 + 12 + 2 cen
    check("B_gap_wait0", falls[2] - falls[1], 28);  // 5 + 2 cen

    // POLL chip 1 mask 0x2; unmasked bits stay busy after release.
    load(0, 3'b010, 2'd1, 8'h02); load(1, 3'b000, 2'd1, 8'h5A); load(2, 3'b100, 2'd0, 8'h00);
    ch_busy = 8'h2F;
    pulse_start();
    repeat (200) @(negedge clk);
    check("C_stall_busy", busy, 1); check("C_stall_pc", pc, 0);
    check("C_stall_nowr", obs_q.size(), 0);
    @(posedge clk iff cen);
    repeat (3) @(posedge clk);
    @(negedge clk);
    ch_busy = 8'hDF; rel = cyc;
    exp_q.push_back('{1, 8'h5A});
    wait_idle(2000, "C_idle");
    compare_writes("C");
    check("C_latency", falls[0] - rel, 9);  // next cen edge + FETCH + DECODE
    ch_busy = '0;

    // Full 32-entry loop: sel=3 writes (no strobe) and JUMP 0 at the last entry.
    for (int i = 0; i < 31; i++) load(i, 3'b000, 2'd3, 8'(i));
    load(31, 3'b011, 2'd0, 8'd0);
    pulse_start();
    wait_pc(31, 1000, "D_reach31");
    wait_pc(0, 100, "D_wrap0");
    wait_pc(20, 1000, "D_reach20");
    pulse_start();
    repeat (10) @(negedge clk);
    check("D_start_ignored", pc, 21);
    load(31, 3'b100, 2'd0, 8'h00);
    wait_pc(31, 1000, "D_reach31b");
    wait_pc(0, 100, "D_wrap0b");
    check("D_ram_protect", busy, 1);
    check("D_nowr", obs_q.size(), 0);
    check("D_wrn", wrn, 3);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("D_rst_busy", busy, 0); check("D_rst_pc", pc, 0);
    rst_n = 1'b1;

    // Reset during WRLO, then replay proves the RAM survived reset.
    load(0, 3'b000, 2'd1, 8'h3C); load(1, 3'b100, 2'd0, 8'h00);
    pulse_start();
    begin
      int n = 0;
      while (wrn[1] !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      check("E_strobe_seen", wrn[1], 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("E_rst_wrn", wrn, 3); check("E_rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    obs_q.delete();
    repeat (100) @(negedge clk);
    check("E_no_more_wr", obs_q.size(), 0); check("E_idle", busy, 0);
    exp_q.push_back('{1, 8'h3C});
    pulse_start();
    wait_idle(2000, "E_idle2");
    compare_writes("E");

`ifdef JT6295_SEQ_ABORT_EN
    // abort beats a simultaneous start during WAIT.
    load(0, 3'b001, 2'd0, 8'd10); load(1, 3'b000, 2'd0, 8'h99); load(2, 3'b100, 2'd0, 8'h00);
    d0 = done_cnt;
    pulse_start();
    repeat (40) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("F_busy", busy, 0);
    repeat (300) @(negedge clk);
    check("F_no_restart", busy, 0); check("F_nowr", obs_q.size(), 0);
    check("F_no_done", done_cnt - d0, 0); check("F_wrn", wrn, 3);
`endif

    check("one_wrn_low", overlap_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
